// File: rtl/sdram_stream_writer.sv
// Stream-to-Avalon-MM write master: buffers a run of words and writes them to consecutive SDRAM word addresses.
// Optional stall counter output enabled by defining SDRAM_STREAM_WRITER_STATS_EN.
module sdram_stream_writer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 25,
    parameter int LEN_W      = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [LEN_W-1:0]    cfg_len,
    output logic                busy,
    output logic                done,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_write,
    input  logic                avm_waitrequest,
`ifdef SDRAM_STREAM_WRITER_STATS_EN
    output logic [31:0]         stall_cycles,
`endif
    output logic [1:0]          fsm_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic [LEN_W-1:0]  in_remaining, wr_remaining;
    logic              fifo_empty, fifo_full;
    logic              start_ok, push, accept, load, last_accept;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign start_ok    = (state == IDLE) && start;
    assign push        = in_valid && in_ready;
    assign accept      = avm_write && !avm_waitrequest;
    assign load        = (state == RUN) && !fifo_empty && (!avm_write || !avm_waitrequest);
    assign last_accept = accept && (wr_remaining == LEN_W'(1));

    assign avm_byteenable = '1;
    assign fsm_state      = state;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (cfg_len == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = !fifo_full && (in_remaining != '0);
                if (last_accept) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= in_data;
        end
    end

    // A load in the same cycle as an accept overrides the deassert, giving back-to-back writes.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            in_remaining  <= '0;
            wr_remaining  <= '0;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_write     <= 1'b0;
        end else begin
            if (start_ok) begin
                avm_address  <= cfg_base;
                in_remaining <= cfg_len;
                wr_remaining <= cfg_len;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
            end
            if (push) begin
                wr_ptr       <= wr_ptr + 1'b1;
                in_remaining <= in_remaining - LEN_W'(1);
            end
            if (accept) begin
                avm_address  <= avm_address + ADDR_W'(1);
                wr_remaining <= wr_remaining - LEN_W'(1);
                avm_write    <= 1'b0;
            end
            if (load) begin
                avm_writedata <= mem[rd_ptr[PTR_W-1:0]];
                avm_write     <= 1'b1;
                rd_ptr        <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef SDRAM_STREAM_WRITER_STATS_EN
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if (avm_write && avm_waitrequest && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_stream_writer.sv
// Scoreboard bench for sdram_stream_writer: accepted stream words predict address/data of each accepted write.
// Also checks stall_cycles when SDRAM_STREAM_WRITER_STATS_EN is defined.
module tb_sdram_stream_writer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 25;
    localparam int LEN_W  = 24;

    logic              clk_clk;
    logic              reset_reset;
    logic              start;
    logic [ADDR_W-1:0] cfg_base;
    logic [LEN_W-1:0]  cfg_len;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] avm_address;
    logic [DATA_W-1:0] avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_write;
    logic              avm_waitrequest;
    logic [1:0]        fsm_state;
`ifdef SDRAM_STREAM_WRITER_STATS_EN
    logic [31:0]       stall_cycles;
`endif

    sdram_stream_writer dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .start          (start),
        .cfg_base       (cfg_base),
        .cfg_len        (cfg_len),
        .busy           (busy),
        .done           (done),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .avm_address    (avm_address),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_write      (avm_write),
        .avm_waitrequest(avm_waitrequest),
`ifdef SDRAM_STREAM_WRITER_STATS_EN
        .stall_cycles   (stall_cycles),
`endif
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc++;

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] item;
    logic [ADDR_W-1:0]        nxt_addr = '0;
    int  acc_cnt = 0, wr_total = 0, push_cnt = 0, done_cnt = 0;
    int  stall_obs = 0, inready_cnt = 0, first_acc = 0, last_acc = 0;
    bit  prev_stall = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;

    always @(negedge clk_clk) begin
        if (reset_reset) begin
            prev_stall = 0;
        end else begin
            if (in_ready) inready_cnt++;
            if (in_valid && in_ready) begin
                exp_q.push_back({nxt_addr, in_data});
                nxt_addr = nxt_addr + 1'b1;
                push_cnt++;
            end
            if (prev_stall) begin
                check("hold_write", avm_write, 1);
                check("hold_addr", avm_address, prev_addr);
                check("hold_data", avm_writedata, prev_data);
            end
            prev_stall = 0;
            if (avm_write) begin
                check("byteenable", avm_byteenable, 4'hF);
                if (avm_waitrequest) begin
                    stall_obs++;
                    prev_stall = 1;
                    prev_addr  = avm_address;
                    prev_data  = avm_writedata;
                end else begin
                    check("write_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        item = exp_q.pop_front();
                        check("wr_addr", avm_address, item[ADDR_W+DATA_W-1:DATA_W]);
                        check("wr_data", avm_writedata, item[DATA_W-1:0]);
                    end
                    acc_cnt++;
                    wr_total++;
                    if (acc_cnt == 1) first_acc = cyc;
                    last_acc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_q_empty", exp_q.size(), 0);
                check("done_busy", busy, 0);
            end
        end
    end

    // ---------------- waitrequest driver ----------------
    bit hold_wr    = 0;
    int stall_idx  = -1;
    int stall_left = 0;

    always begin
        @(posedge clk_clk);
        #1;
        if (avm_write && stall_left > 0 && acc_cnt == stall_idx) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end else begin
            avm_waitrequest = hold_wr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        @(posedge clk_clk);
        #1;
        start    = 1'b1;
        cfg_base = base;
        cfg_len  = len;
        nxt_addr = base;
        acc_cnt  = 0;
        @(posedge clk_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_words(input logic [DATA_W-1:0] d0, input int n, input bit rnd);
        bit ok;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = rnd ? $urandom_range(32'hFFFF_FFFF, 0) : d0 + i;
            ok = 0;
            for (int k = 0; k < 200 && !ok; k++) begin
                @(negedge clk_clk);
                ok = in_ready;
                @(posedge clk_clk);
                #1;
            end
            if (!ok) check("send_timeout", ok, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk_clk);
            k++;
        end
        check("done_seen", done_cnt - d0, 1);
        repeat (4) @(posedge clk_clk);
        check("single_done", done_cnt - d0, 1);
        check("idle_busy", busy, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c0, pc, so, ir, wt;
        reset_reset = 1'b1;
        start = 1'b0; cfg_base = '0; cfg_len = '0;
        in_data = '0; in_valid = 1'b0; avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk_clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_write", avm_write, 0);
        check("rst_addr", avm_address, 0);
        check("rst_data", avm_writedata, 0);
        check("rst_state", fsm_state, 0);
        reset_reset = 1'b0;

        // basic, no stall
        start_run(25'h100, 4);
        check("basic_busy", busy, 1);
        send_words(32'hA0, 4, 0);
        wait_done(100);
        check("basic_count", acc_cnt, 4);
        check("basic_back2back", last_acc - first_acc, 3);

        // stall on the second write
        stall_idx = 1; stall_left = 5; so = stall_obs;
        start_run(25'h200, 3);
        c0 = cyc;
        send_words(32'hB0, 3, 0);
        check("stall_send_cycles", cyc - c0, 3);
        wait_done(100);
        check("stall_obs", stall_obs - so, 5);
        check("stall_count", acc_cnt, 3);
`ifdef SDRAM_STREAM_WRITER_STATS_EN
        check("stall_cycles", stall_cycles, 5);
`endif
        stall_idx = -1;

        // backpressure
        hold_wr = 1;
        start_run(25'h300, 20);
        pc = push_cnt;
        fork
            send_words(32'h0, 20, 1);
            begin
                repeat (30) @(posedge clk_clk);
                #2;
                check("bp_pushes", push_cnt - pc, 9);
                check("bp_inready", in_ready, 0);
                hold_wr = 0;
            end
        join
        wait_done(200);
        check("bp_count", acc_cnt, 20);

        // zero length, with in_valid held high
        ir = inready_cnt; wt = wr_total; pc = push_cnt;
        in_valid = 1'b1; in_data = 32'hDEAD;
        start_run(25'h400, 0);
        @(negedge clk_clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk_clk);
        check("zero_done_once", done, 0);
        repeat (3) @(posedge clk_clk);
        #1;
        in_valid = 1'b0;
        check("zero_inready", inready_cnt - ir, 0);
        check("zero_writes", wr_total - wt, 0);
        check("idle_no_push", push_cnt - pc, 0);

        // address wrap and ignored start
        start_run(25'h1FF_FFFF, 2);
        fork
            send_words(32'hC0, 2, 0);
            begin
                @(posedge clk_clk);
                #1;
                start = 1'b1; cfg_base = 25'h55; cfg_len = 7;
                @(posedge clk_clk);
                #1;
                start = 1'b0;
            end
        join
        wait_done(100);
        check("wrap_count", acc_cnt, 2);
        wt = wr_total;
        repeat (6) @(posedge clk_clk);
        check("ignore_busy", busy, 0);
        check("ignore_writes", wr_total - wt, 0);

        // reset during a stalled write
        hold_wr = 1;
        start_run(25'h500, 3);
        send_words(32'hD0, 1, 0);
        repeat (3) @(posedge clk_clk);
        #2;
        check("rst_pre_write", avm_write, 1);
        #1;
        reset_reset = 1'b1;
        #1;
        check("rst_mid_write", avm_write, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", in_ready, 0);
        exp_q.delete();
        hold_wr = 0;
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        start_run(25'h600, 1);
        send_words(32'hE0, 1, 0);
        wait_done(100);
        check("post_rst_count", acc_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
